// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset datapath: PC, 32x32 register file, IR/DR/A/B/C
// inter-cycle registers, ALU and memory address/data muxing.
module mc_datapath #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        write_pc,
   input  logic        write_ir,
   input  logic        write_dr,
   input  logic        write_a,
   input  logic        write_b,
   input  logic        write_c,
   input  logic        write_reg,
   input  logic        write_mem,
   input  logic        iord,
   input  logic        memtoreg,
   input  logic        regdst,
   input  logic [1:0]  pcsource,
   input  logic [1:0]  alu_ctrl,
   input  logic        alu_srcA,
   input  logic [1:0]  alu_srcB,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic [31:0] ir_data,
   output logic        zero,
   output logic [31:0] pc,
   input  logic [4:0]  dbg_sel,
   output logic [31:0] dbg_data
);

   localparam int unsigned W    = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned RW   = 5;

   logic [W-1:0]  pc_q, pc_d;
   logic [W-1:0]  ir_q, dr_q, a_q, b_q, c_q;
   logic [W-1:0]  rf_q [NREG];

   logic [RW-1:0] rs, rt, dst;
   logic [W-1:0]  rs_val, rt_val, sext, alu_a, alu_b, alu_y, wb_data;

   // Field decode and asynchronous register-file reads (r0 reads zero)
   always_comb begin
      rs      = ir_q[25:21];
      rt      = ir_q[20:16];
      dst     = regdst ? ir_q[15:11] : ir_q[20:16];
      rs_val  = (rs == '0) ? '0 : rf_q[rs];
      rt_val  = (rt == '0) ? '0 : rf_q[rt];
      sext    = {{16{ir_q[15]}}, ir_q[15:0]};
      wb_data = memtoreg ? dr_q : c_q;
   end

   // ALU operand selection and operation
   always_comb begin
      alu_a = alu_srcA ? a_q : pc_q;
      case (alu_srcB)
         2'b00:   alu_b = b_q;
         2'b01:   alu_b = PC_STEP;
         2'b10:   alu_b = sext;
         default: alu_b = {sext[W-3:0], 2'b00};
      endcase
      case (alu_ctrl)
         2'b00:   alu_y = alu_a + alu_b;
         2'b01:   alu_y = alu_a - alu_b;
         2'b11:   alu_y = alu_a & alu_b;
         default: alu_y = ~(alu_a | alu_b);
      endcase
   end

   // Next-PC mux; jump target uses the PC value before this edge
   always_comb begin
      case (pcsource)
         2'b00:   pc_d = alu_y;
         2'b01:   pc_d = c_q;
         2'b10:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
         default: pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= PC_RESET;
         ir_q <= '0;
         dr_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
         c_q  <= '0;
      end else begin
         if (write_pc) pc_q <= pc_d;
         if (write_ir) ir_q <= mem_rdata;
         if (write_dr) dr_q <= mem_rdata;
         if (write_a)  a_q  <= rs_val;
         if (write_b)  b_q  <= rt_val;
         if (write_c)  c_q  <= alu_y;
      end
   end

   // Register file write port; writes to r0 are dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (write_reg && (dst != '0)) begin
         rf_q[dst] <= wb_data;
      end
   end

   assign mem_addr  = iord ? c_q : pc_q;
   assign mem_wdata = b_q;
   assign mem_we    = write_mem;
   assign ir_data   = ir_q;
   assign zero      = (alu_y == '0);
   assign pc        = pc_q;
   assign dbg_data  = (dbg_sel == '0) ? '0 : rf_q[dbg_sel];

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: directed instruction sequences plus random control
// words, all checked against an architectural-state model.
module tb_mc_datapath;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_pc, write_ir, write_dr, write_a, write_b, write_c, write_reg, write_mem;
   logic        iord, memtoreg, regdst, alu_srcA;
   logic [1:0]  pcsource, alu_ctrl, alu_srcB;
   logic [31:0] mem_rdata, mem_addr, mem_wdata, ir_data, pc, dbg_data;
   logic        mem_we, zero;
   logic [4:0]  dbg_sel;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic wpc, wir, wdr, wa, wb, wc, wreg, wmem;
      logic iord, m2r, rdst, srca;
      logic [1:0] pcs, aluc, srcb;
      logic [31:0] rdata;
      logic [4:0]  dsel;
   } ctl_t;

   // Architectural model state
   logic [31:0] m_pc, m_ir, m_dr, m_a, m_b, m_c;
   logic [31:0] m_rf [32];

   mc_datapath dut (
      .clk(clk), .rst(rst),
      .write_pc(write_pc), .write_ir(write_ir), .write_dr(write_dr),
      .write_a(write_a), .write_b(write_b), .write_c(write_c),
      .write_reg(write_reg), .write_mem(write_mem),
      .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
      .pcsource(pcsource), .alu_ctrl(alu_ctrl), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .ir_data(ir_data), .zero(zero), .pc(pc), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic ctl_t idle();
      ctl_t c;
      c = '{default: '0};
      c.pcs   = 2'b11;
      c.rdata = $urandom;
      c.dsel  = 5'($urandom_range(0, 31));
      return c;
   endfunction

   task automatic apply(input ctl_t c);
      write_pc = c.wpc;  write_ir = c.wir;  write_dr = c.wdr;  write_a = c.wa;
      write_b  = c.wb;   write_c  = c.wc;   write_reg = c.wreg; write_mem = c.wmem;
      iord = c.iord; memtoreg = c.m2r; regdst = c.rdst; alu_srcA = c.srca;
      pcsource = c.pcs; alu_ctrl = c.aluc; alu_srcB = c.srcb;
      mem_rdata = c.rdata; dbg_sel = c.dsel;
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] r);
      return (r == 5'd0) ? 32'd0 : m_rf[r];
   endfunction

   function automatic logic [31:0] m_alu(input ctl_t c);
      logic [31:0] x, y, imm;
      imm = 32'($signed(m_ir[15:0]));
      x   = c.srca ? m_a : m_pc;
      case (c.srcb)
         2'd0: y = m_b;
         2'd1: y = 32'd4;
         2'd2: y = imm;
         default: y = imm * 32'd4;
      endcase
      case (c.aluc)
         2'd0: return x + y;
         2'd1: return x - y;
         2'd3: return x & y;
         default: return ~(x | y);
      endcase
   endfunction

   task automatic m_reset();
      m_pc = 32'd0; m_ir = 0; m_dr = 0; m_a = 0; m_b = 0; m_c = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
   endtask

   // Every enabled register loads from values present before the edge
   task automatic m_advance(input ctl_t c);
      logic [31:0] res, npc, na, nb;
      logic [4:0]  dst;
      res = m_alu(c);
      na  = m_read(m_ir[25:21]);
      nb  = m_read(m_ir[20:16]);
      dst = c.rdst ? m_ir[15:11] : m_ir[20:16];
      case (c.pcs)
         2'd0: npc = res;
         2'd1: npc = m_c;
         2'd2: npc = {m_pc[31:28], m_ir[25:0], 2'b00};
         default: npc = m_pc;
      endcase
      if (c.wreg && dst != 5'd0) m_rf[dst] = c.m2r ? m_dr : m_c;
      if (c.wpc) m_pc = npc;
      if (c.wc)  m_c  = res;
      if (c.wa)  m_a  = na;
      if (c.wb)  m_b  = nb;
      if (c.wir) m_ir = c.rdata;
      if (c.wdr) m_dr = c.rdata;
   endtask

   // One clock: check combinational outputs, advance model, check registers
   task automatic step(input ctl_t c);
      apply(c);
      #1;
      chk("zero",  {31'd0, zero},   {31'd0, (m_alu(c) == 32'd0)});
      chk("maddr", mem_addr,        c.iord ? m_c : m_pc);
      chk("we",    {31'd0, mem_we}, {31'd0, c.wmem});
      chk("dbg",   dbg_data,        m_read(c.dsel));
      m_advance(c);
      @(posedge clk); #1;
      chk("pc",    pc,        m_pc);
      chk("ir",    ir_data,   m_ir);
      chk("wdata", mem_wdata, m_b);
      @(negedge clk);
   endtask

   task automatic preload(input logic [4:0] r, input logic [31:0] v);
      ctl_t c;
      c = idle(); c.wir = 1; c.rdata = {6'h23, 5'd0, r, 16'h0}; step(c);
      c = idle(); c.wdr = 1; c.rdata = v; step(c);
      c = idle(); c.wreg = 1; c.m2r = 1; step(c);
   endtask

   task automatic load_ir(input logic [31:0] v);
      ctl_t c;
      c = idle(); c.wir = 1; c.rdata = v; step(c);
   endtask

   task automatic load_ab();
      ctl_t c;
      c = idle(); c.wa = 1; c.wb = 1; step(c);
   endtask

   task automatic rtype(input logic [31:0] instr, input logic [1:0] op);
      ctl_t c;
      load_ir(instr);
      load_ab();
      c = idle(); c.srca = 1; c.srcb = 2'b00; c.aluc = op; c.wc = 1; step(c);
      c = idle(); c.wreg = 1; c.rdst = 1; c.m2r = 0; step(c);
   endtask

   task automatic peek_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
      ctl_t c;
      c = idle(); c.dsel = r; apply(c); #1;
      chk(tag, dbg_data, exp);
   endtask

   initial begin
      ctl_t c;
      rst = 1'b1;
      c = idle(); c.rdata = 32'h8C22_0004; c.dsel = 5'd3; apply(c);
      m_reset();
      #12;
      chk("rst_pc", pc, 32'h0);
      chk("rst_ir", ir_data, 32'h0);
      chk("rst_maddr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_dbg", dbg_data, 32'h0);
      @(negedge clk); rst = 1'b0;

      // Instruction fetch
      c = idle(); c.wpc = 1; c.wir = 1; c.pcs = 2'b00; c.srcb = 2'b01; c.rdata = 32'h8C22_0004;
      step(c);
      chk("if_pc", pc, 32'd4);
      chk("if_ir", ir_data, 32'h8C22_0004);

      // R-type add/sub/nor
      preload(5'd1, 32'd5);
      preload(5'd2, 32'd7);
      rtype(32'h0022_1820, 2'b00);
      peek_reg("add_r3", 5'd3, 32'd12);
      rtype(32'h0022_2022, 2'b01);
      peek_reg("sub_r4", 5'd4, 32'hFFFF_FFFE);
      rtype(32'h0022_2827, 2'b10);
      peek_reg("nor_r5", 5'd5, 32'hFFFF_FFF8);

      // Load/store address and data
      preload(5'd6, 32'h100);
      preload(5'd7, 32'hCAFE_F00D);
      load_ir(32'h8CC7_0008);
      load_ab();
      c = idle(); c.srca = 1; c.srcb = 2'b10; c.wc = 1; step(c);
      c = idle(); c.iord = 1; c.wmem = 1; apply(c); #1;
      chk("ls_addr", mem_addr, 32'h108);
      chk("st_we", {31'd0, mem_we}, 32'd1);
      chk("st_wdata", mem_wdata, 32'hCAFE_F00D);
      step(c);
      c = idle(); c.iord = 1; c.wdr = 1; c.rdata = 32'hDEAD_BEEF; step(c);
      c = idle(); c.wreg = 1; c.m2r = 1; c.rdst = 0; step(c);
      peek_reg("lw_r7", 5'd7, 32'hDEAD_BEEF);

      // Branch: PC=8, offset 3 words
      c = idle(); c.wpc = 1; c.pcs = 2'b00; c.srcb = 2'b01; step(c);
      preload(5'd8, 32'd9);
      preload(5'd9, 32'd9);
      preload(5'd10, 32'd3);
      load_ir(32'h1109_0003);
      c = idle(); c.srca = 0; c.srcb = 2'b11; c.wc = 1; step(c);
      load_ab();
      c = idle(); c.srca = 1; c.aluc = 2'b01; c.pcs = 2'b01; c.wpc = 1; apply(c); #1;
      chk("beq_zero", {31'd0, zero}, 32'd1);
      step(c);
      chk("beq_pc", pc, 32'd20);
      load_ir(32'h110A_0003);
      load_ab();
      c = idle(); c.srca = 1; c.aluc = 2'b01; apply(c); #1;
      chk("bne_zero", {31'd0, zero}, 32'd0);

      // Jump within the current 256MB region
      preload(5'd11, 32'h1000_0000);
      load_ir(32'h0160_0004);
      load_ab();
      c = idle(); c.srca = 1; c.srcb = 2'b10; c.pcs = 2'b00; c.wpc = 1; step(c);
      chk("pre_j_pc", pc, 32'h1000_0004);
      load_ir(32'h0800_0040);
      c = idle(); c.pcs = 2'b10; c.wpc = 1; step(c);
      chk("j_pc", pc, 32'h1000_0100);

      // PC wrap and hold
      preload(5'd12, 32'hFFFF_FFF8);
      load_ir(32'h0180_0004);
      load_ab();
      c = idle(); c.srca = 1; c.srcb = 2'b10; c.pcs = 2'b00; c.wpc = 1; step(c);
      chk("wrap_pre", pc, 32'hFFFF_FFFC);
      c = idle(); c.wpc = 1; c.pcs = 2'b00; c.srcb = 2'b01; step(c);
      chk("wrap_pc", pc, 32'h0);
      c = idle(); c.wpc = 1; c.pcs = 2'b11; step(c);
      chk("hold_pc", pc, 32'h0);

      // r0 stays zero
      preload(5'd0, 32'h1234);
      peek_reg("r0", 5'd0, 32'h0);

      // Random control words
      for (int n = 0; n < 400; n++) begin
         c = idle();
         {c.wpc, c.wir, c.wdr, c.wa, c.wb, c.wc, c.wreg, c.wmem} = 8'($urandom);
         {c.iord, c.m2r, c.rdst, c.srca} = 4'($urandom);
         {c.pcs, c.aluc, c.srcb} = 6'($urandom);
         step(c);
      end

      // Asynchronous reset between edges
      c = idle(); c.dsel = 5'd3; apply(c);
      #2 rst = 1'b1;
      #1;
      m_reset();
      chk("arst_pc", pc, 32'h0);
      chk("arst_ir", ir_data, 32'h0);
      chk("arst_maddr", mem_addr, 32'h0);
      chk("arst_wdata", mem_wdata, 32'h0);
      chk("arst_dbg", dbg_data, 32'h0);
      @(negedge clk); rst = 1'b0;
      for (int n = 0; n < 50; n++) begin
         c = idle();
         {c.wpc, c.wir, c.wdr, c.wa, c.wb, c.wc, c.wreg, c.wmem} = 8'($urandom);
         {c.iord, c.m2r, c.rdst, c.srca} = 4'($urandom);
         {c.pcs, c.aluc, c.srcb} = 6'($urandom);
         step(c);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
